seg7_scan_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 29 ++
 rtl/seg7_hex_decode.sv | 13 +
 rtl/seg7_scan_driver.sv | 194 +++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the seven-segment scan driver.
//   - state_t      : scan FSM states, encoded as they appear in STATUS[2:1]
//   - ADDR_*       : Avalon-MM register word addresses
//   - SEG_OFF      : active-low segment pattern with every segment dark
//   - HEX_GLYPH    : active-high glyphs for 0-9, A, b, C, d, E, F.
//                    Bit order is [0]=a .. [6]=g.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_DRIVE = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_DIGITS = 2'd0;
  localparam logic [1:0] ADDR_DP     = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex nibble to seven-segment glyph.
//   nibble : 4-bit hex value
//   seg    : active-high segments, [0]=a .. [6]=g
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_GLYPH[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed common-anode seven-segment display driver.
// Each digit is lit for DIV cycles, followed by BLANK_CYCLES with every digit
// dark so the previous digit's segments cannot ghost onto the next one.
//
// Ports:
//   clk, reset_n   : system clock, asynchronous active-low reset
//   en             : display enable from the enable PIO (same clock domain)
//   address        : Avalon word address (0 DIGITS, 1 DP, 2 DIV, 3 STATUS)
//   chipselect     : Avalon chipselect
//   write_n        : Avalon write strobe, active low
//   writedata      : Avalon write data
//   readdata       : Avalon read data, combinational (zero wait states)
//   seg_n          : segments, active low, [0]=a .. [6]=g, [7]=dp
//   dig_n          : digit selects, active low, bit i = digit i
//
// Bus protocol: a write is committed on every clk edge where
// chipselect && !write_n; there is no wait-request, so every write is
// accepted in its own cycle. Reads return the addressed register in the
// same cycle the address is presented.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int DIV_DEFAULT  = 50000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [7:0]            seg_n,
  output logic [NUM_DIGITS-1:0] dig_n
);

  localparam logic [2:0]  LAST_IDX   = 3'(NUM_DIGITS - 1);
  localparam logic [19:0] BLANK_LAST = 20'(BLANK_CYCLES - 1);
  localparam logic [19:0] DIV_RESET  = 20'(DIV_DEFAULT);

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [31:0] digits_q;
  logic [7:0]  dp_q;
  logic [19:0] div_q;
  logic        wr_en;

  assign wr_en = chipselect && !write_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digits_q <= '0;
      dp_q     <= '0;
      div_q    <= DIV_RESET;
    end else if (wr_en) begin
      case (address)
        ADDR_DIGITS: digits_q <= writedata;
        ADDR_DP:     dp_q     <= writedata[7:0];
        // A zero divider would make the slice compare underflow; clamp to 1.
        ADDR_DIV:    div_q    <= (writedata[19:0] == 20'd0) ? 20'd1 : writedata[19:0];
        default:     ;  // STATUS is read-only
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Scan FSM state
  // ---------------------------------------------------------------------------
  state_t      state_q;
  logic [2:0]  idx_q;
  logic [19:0] cnt_q;

  // ---------------------------------------------------------------------------
  // Digit pattern selection. load_idx is the digit whose pattern the FSM
  // writes to the outputs on this edge: digit 0 when leaving OFF, the next
  // digit when leaving BLANK, otherwise the digit currently being driven.
  // Sharing one decoder across all three cases keeps the pattern path single.
  // ---------------------------------------------------------------------------
  logic [2:0]            next_idx;
  logic [2:0]            load_idx;
  logic [3:0]            nibble;
  logic [6:0]            glyph;
  logic [7:0]            drive_seg;
  logic [NUM_DIGITS-1:0] drive_dig;

  always_comb begin
    next_idx = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
  end

  always_comb begin
    load_idx = idx_q;
    case (state_q)
      ST_OFF:   load_idx = 3'd0;
      ST_BLANK: load_idx = next_idx;
      default:  load_idx = idx_q;
    endcase
  end

  assign nibble = digits_q[{load_idx, 2'b00} +: 4];

  seg7_hex_decode u_hex_decode (
    .nibble (nibble),
    .seg    (glyph)
  );

  assign drive_seg = ~{dp_q[load_idx], glyph};
  assign drive_dig = ~(NUM_DIGITS'(1) << load_idx);

  // ---------------------------------------------------------------------------
  // Scan FSM with registered outputs. en=0 forces OFF from any state.
  // DRIVE ends on cnt >= DIV-1 (not ==) so that lowering DIV below the
  // current count still terminates the slice on the following edge.
  // Register values seen here are those before any write on the same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_OFF;
      idx_q   <= 3'd0;
      cnt_q   <= 20'd0;
      seg_n   <= SEG_OFF;
      dig_n   <= '1;
    end else if (!en) begin
      state_q <= ST_OFF;
      idx_q   <= 3'd0;
      cnt_q   <= 20'd0;
      seg_n   <= SEG_OFF;
      dig_n   <= '1;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_q <= ST_DRIVE;
          idx_q   <= 3'd0;
          cnt_q   <= 20'd0;
          seg_n   <= drive_seg;
          dig_n   <= drive_dig;
        end

        ST_DRIVE: begin
          if (cnt_q >= div_q - 20'd1) begin
            state_q <= ST_BLANK;
            cnt_q   <= 20'd0;
            seg_n   <= SEG_OFF;
            dig_n   <= '1;
          end else begin
            cnt_q <= cnt_q + 20'd1;
            // Refreshed every cycle so register writes show up immediately.
            seg_n <= drive_seg;
            dig_n <= drive_dig;
          end
        end

        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_q <= ST_DRIVE;
            cnt_q   <= 20'd0;
            idx_q   <= next_idx;
            seg_n   <= drive_seg;
            dig_n   <= drive_dig;
          end else begin
            cnt_q <= cnt_q + 20'd1;
            seg_n <= SEG_OFF;
            dig_n <= '1;
          end
        end

        default: begin
          state_q <= ST_OFF;
          idx_q   <= 3'd0;
          cnt_q   <= 20'd0;
          seg_n   <= SEG_OFF;
          dig_n   <= '1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux. STATUS: [0]=en, [2:1]=state, [6:4]=idx.
  // ---------------------------------------------------------------------------
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_DIGITS: readdata = digits_q;
      ADDR_DP:     readdata = {24'd0, dp_q};
      ADDR_DIV:    readdata = {12'd0, div_q};
      ADDR_STATUS: readdata = {25'd0, idx_q, 1'b0, state_q, en};
      default:     readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed bench for seg7_scan_driver with
// NUM_DIGITS=4, BLANK_CYCLES=2 and DIV programmed to 4 for the main scan.
module tb_seg7_scan_driver;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  seg_n;
  logic [3:0]  dig_n;

  int tests_run;
  int tests_failed;

  // Hand-computed active-low patterns for DIGITS=32'h00004321, DP=8'h01.
  logic [7:0] exp_seg [4] = '{8'h79, 8'hA4, 8'hB0, 8'h99};
  logic [3:0] exp_dig [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  seg7_scan_driver #(
    .NUM_DIGITS   (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .seg_n      (seg_n),
    .dig_n      (dig_n)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking and driver tasks
  // ---------------------------------------------------------------------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic check_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check_eq(tag, readdata, exp);
  endtask

  task automatic check_out(input string tag, input logic [7:0] s, input logic [3:0] d);
    check_eq({tag, "_seg"}, {24'd0, seg_n}, {24'd0, s});
    check_eq({tag, "_dig"}, {28'd0, dig_n}, {28'd0, d});
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    en           = 1'b1;
    address      = 2'd0;
    chipselect   = 1'b0;
    write_n      = 1'b1;
    writedata    = 32'd0;

    // Reset held with en high: outputs stay dark.
    tick();
    tick();
    check_out("reset", 8'hFF, 4'hF);
    check_rd("reset_div", 2'd2, 32'd50000);
    check_rd("reset_digits", 2'd0, 32'd0);
    check_rd("reset_status", 2'd3, 32'h1);

    en      = 1'b0;
    reset_n = 1'b1;
    tick();
    check_out("idle_off", 8'hFF, 4'hF);

    // Configure, then confirm an addr3 write changes nothing.
    bus_write(2'd0, 32'h0000_4321);
    bus_write(2'd1, 32'h0000_0001);
    bus_write(2'd2, 32'd4);
    bus_write(2'd3, 32'hFFFF_FFFF);
    check_rd("ro_digits", 2'd0, 32'h0000_4321);
    check_rd("ro_dp", 2'd1, 32'h1);
    check_rd("ro_div", 2'd2, 32'd4);
    check_rd("status_off", 2'd3, 32'h0);

    // Basic scan: first lit output one edge after en is sampled high.
    en = 1'b1;
    tick();
    check_rd("status_drive0", 2'd3, 32'h3);
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        check_out($sformatf("scan_d%0d_c%0d", d, c), exp_seg[d], exp_dig[d]);
        tick();
      end
      for (int b = 0; b < 2; b++) begin
        check_out($sformatf("scan_blank_d%0d_b%0d", d, b), 8'hFF, 4'hF);
        if (d == 1 && b == 0) check_rd("status_blank1", 2'd3, 32'h15);
        tick();
      end
    end
    check_out("scan_wrap", exp_seg[0], exp_dig[0]);

    // Disable mid-slice during digit 2.
    for (int i = 0; i < 12; i++) tick();
    check_out("pre_disable_d2", exp_seg[2], exp_dig[2]);
    check_rd("status_drive2", 2'd3, 32'h23);
    en = 1'b0;
    tick();
    check_out("disable_off", 8'hFF, 4'hF);
    check_rd("status_disabled", 2'd3, 32'h0);
    en = 1'b1;
    tick();
    check_out("reenable_d0", exp_seg[0], exp_dig[0]);
    check_rd("status_reenable", 2'd3, 32'h3);

    // DIV=0 is stored as 1: one lit cycle per digit.
    en = 1'b0;
    tick();
    bus_write(2'd2, 32'd0);
    check_rd("div0_readback", 2'd2, 32'd1);
    en = 1'b1;
    tick();
    check_out("div1_d0", exp_seg[0], exp_dig[0]);
    tick();
    check_out("div1_blank_a", 8'hFF, 4'hF);
    tick();
    check_out("div1_blank_b", 8'hFF, 4'hF);
    tick();
    check_out("div1_d1", exp_seg[1], exp_dig[1]);
    tick();
    check_out("div1_d1_end", 8'hFF, 4'hF);

    // Lowering DIV mid-slice ends the slice on the edge after the write.
    en = 1'b0;
    tick();
    bus_write(2'd2, 32'd8);
    en = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check_out("div8_cnt3", exp_seg[0], exp_dig[0]);
    bus_write(2'd2, 32'd2);
    check_out("divchg_write_edge", exp_seg[0], exp_dig[0]);
    tick();
    check_out("divchg_end", 8'hFF, 4'hF);
    check_rd("status_divchg", 2'd3, 32'h5);
    check_rd("div2_readback", 2'd2, 32'd2);

    // Live update of digit 0 while it is lit; slice length is unchanged.
    en = 1'b0;
    tick();
    bus_write(2'd2, 32'd4);
    en = 1'b1;
    tick();
    check_out("live_c0", 8'h79, 4'b1110);
    bus_write(2'd0, 32'h0000_432F);
    check_out("live_write_edge", 8'h79, 4'b1110);
    tick();
    check_out("live_new_glyph", 8'h0E, 4'b1110);
    tick();
    check_out("live_c3", 8'h0E, 4'b1110);
    tick();
    check_out("live_slice_end", 8'hFF, 4'hF);

    // Asynchronous reset mid-scan.
    tick();
    tick();
    check_out("prereset_d1", exp_seg[1], exp_dig[1]);
    reset_n = 1'b0;
    #1;
    check_out("async_reset", 8'hFF, 4'hF);
    check_rd("async_reset_digits", 2'd0, 32'd0);
    check_rd("async_reset_dp", 2'd1, 32'd0);
    check_rd("async_reset_div", 2'd2, 32'd50000);
    check_rd("async_reset_status", 2'd3, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
